// File: rtl/reg_write_decoder.sv
// ---------------------------------------------------------------------------
// reg_write_decoder
//
// Turns the write-back stage's destination-register index into one-hot
// register-file write strobes. Requests pass through a small in-order queue
// with valid/ready handshakes on both sides. A buffered request stays at the
// output until the register file accepts it.
//
// Optional feature macro: DECODER_BYPASS_EN
//   defined   -> an empty queue forwards the input request to the outputs in
//                the same cycle; if accepted there, it is never queued.
//   undefined -> no input-to-output combinational path (latency >= 1 cycle).
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   in_valid    in   request present
//   in_ready    out  queue can accept (occupancy != DEPTH)
//   in_sel      in   [SEL_W]   destination register index
//   in_enable   in   write enable (0 = transfer without a strobe)
//   out_valid   out  decoded request present
//   out_ready   in   register file accepts
//   out_onehot  out  [2**SEL_W] write strobes
//   out_sel     out  [SEL_W]   head index
//   out_enable  out  head enable
//   occupancy   out  [CNT_W]   entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module reg_write_decoder #(
  parameter int SEL_W = 5,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2**SEL_W-1:0]   out_onehot,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_enable,
  output logic [CNT_W-1:0]      occupancy
);

  localparam int OUT_W   = 2**SEL_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = SEL_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] EMPTY_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);

  // Strobe decode: a disabled entry produces no strobe at all.
  function automatic logic [OUT_W-1:0] decode_onehot(input logic [SEL_W-1:0] sel,
                                                     input logic             en);
    decode_onehot = OUT_W'(en) << sel;
  endfunction

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   occ_r;

  logic               fifo_valid_s;
  logic               bypass_s;
  logic               push_s;
  logic               pop_s;
  logic [ENTRY_W-1:0] head_s;
  logic               valid_s;
  logic [SEL_W-1:0]   sel_s;
  logic               en_s;

  // Handshake decisions and head/bypass output selection.
  always_comb begin
    fifo_valid_s = (occ_r != EMPTY_CNT);
    head_s       = mem_r[rd_ptr_r];
`ifdef DECODER_BYPASS_EN
    // Gated by reset_n so the outputs read all-zero while reset is held.
    bypass_s     = reset_n && !fifo_valid_s && in_valid;
`else
    bypass_s     = 1'b0;
`endif
    in_ready     = (occ_r != FULL_CNT);
    valid_s      = fifo_valid_s || bypass_s;
    if (bypass_s) begin
      sel_s = in_sel;
      en_s  = in_enable;
    end else if (fifo_valid_s) begin
      sel_s = head_s[SEL_W-1:0];
      en_s  = head_s[SEL_W];
    end else begin
      // Empty queue: never expose stale storage.
      sel_s = {SEL_W{1'b0}};
      en_s  = 1'b0;
    end
    // A bypassed request accepted this cycle is complete and is not stored.
    push_s = in_valid && in_ready && !(bypass_s && out_ready);
    pop_s  = fifo_valid_s && out_ready;
  end

  // Output drive from the selected request.
  always_comb begin
    out_valid  = valid_s;
    out_sel    = sel_s;
    out_enable = en_s;
    out_onehot = decode_onehot(sel_s, en_s);
    occupancy  = occ_r;
  end

  // Queue storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_enable, in_sel};
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**PTR_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= EMPTY_CNT;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + ONE_CNT;
        2'b01:   occ_r <= occ_r - ONE_CNT;
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: doc/reg_write_decoder.md
# reg_write_decoder

Parametrised SEL_W-to-2^SEL_W one-hot decoder with an enable input and a small input queue. It converts the write-back stage's destination-register index into one-hot write strobes for the register file, and keeps requests in order with a valid/ready handshake. A buffered request is held at the output until the register file accepts it, so a stalled write port cannot drop a write.

## Interface
Parameters:
- SEL_W, 5: select width; OUT_W = 2**SEL_W strobes; legal range 1..6.
- DEPTH, 2: queue entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH+1): occupancy width (derived).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  queue can accept; equals (occupancy != DEPTH); no combinational path from out_ready.
- in_sel  in  SEL_W  register index.
- in_enable  in  1  write enable; 0 means a transfer with no strobe.
- out_valid  out  1  decoded request present.
- out_ready  in  1  register file accepts.
- out_onehot  out  OUT_W  out_onehot[i] = out_enable && (out_sel == i).
- out_sel  out  SEL_W  head index (pass-through for debug and forwarding).
- out_enable  out  1  head enable.
- occupancy  out  CNT_W  entries held, 0..DEPTH.

## Operation
- Push occurs when in_valid && in_ready; the queue stores {in_enable, in_sel} at the write pointer.
- Pop occurs when out_valid && out_ready; the read pointer advances.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- occupancy changes by +1 on push only, by -1 on pop only, and is unchanged on simultaneous push and pop.
- out_valid = (occupancy != 0).
- out_sel, out_enable and out_onehot come combinationally from the head entry.
- When out_valid=0, out_onehot, out_sel and out_enable are all zero; stale entries must never show.
- Order is strict FIFO; no reordering or merging of duplicate indices.
- in_enable=0 entries still occupy a slot and still handshake, with out_onehot=0.
- Full (occupancy=DEPTH): in_ready=0. A pop in the same cycle does not raise in_ready that cycle; it rises the next cycle.
- Empty: a pop cannot occur because out_valid=0.
- A push and a pop in the same cycle while full cannot happen (in_ready=0).
- in_valid without in_ready: the request is held by the source and the block ignores it.
- Reset (asynchronous assert at any time, including mid-transfer):
  - pointers=0, occupancy=0, queue contents are don't-care;
  - outputs go immediately to out_valid=0, out_onehot=0, out_sel=0, out_enable=0, in_ready=1;
  - in-flight entries are discarded.
- Reset deassertion is synchronous to clk; the first push is possible on the first edge after deassertion.

## Timing
- Latency without bypass: a request pushed at edge N appears at out_valid after edge N and is poppable at edge N+1; one cycle minimum.
- Throughput: one push and one pop per cycle in steady state when DEPTH>=2.
- Combinational paths:
  - out_ready -> nothing;
  - in_valid/in_sel/in_enable -> outputs only under DECODER_BYPASS_EN.
- All state updates happen on the rising clk edge.

## Configuration
- DECODER_BYPASS_EN defined:
  - when occupancy=0 and in_valid=1, the outputs reflect the input in the same cycle: out_valid=1, out_sel=in_sel, out_enable=in_enable, out_onehot decoded from in_sel;
  - if out_ready=1 in that cycle, the request completes with zero latency and is not written to the queue;
  - if out_ready=0, it is pushed normally, provided in_ready=1.
- DECODER_BYPASS_EN undefined: no input-to-output combinational path; latency is always at least one cycle.

## Test plan
- Reset then single request: in_sel=5, in_enable=1, out_ready=1, SEL_W=5.
  - No bypass: out_onehot=32'h0000_0020 one cycle later.
  - Bypass: the same value in the same cycle, and occupancy stays 0.
- Enable low: in_sel=3, in_enable=0 -> out_valid=1, out_onehot=0, out_sel=3; the pop completes.
- Fill with DEPTH=2 and out_ready=0: push 7 then 9 -> occupancy=2, in_ready=0.
  - A third in_valid is held.
  - Raise out_ready -> pops 7 then 9 in order (strobe bits 7 then 9); in_ready returns one cycle after the first pop.
- Wrap and simultaneous push/pop, DEPTH=4, streaming 0..11 with out_ready=1:
  - output sequence is 0..11 unbroken;
  - occupancy never exceeds 1 (no bypass) or stays 0 (bypass).
- Async reset mid-operation with occupancy=2: assert reset_n=0 between edges -> out_valid=0 and out_onehot=0 immediately, in_ready=1; after release, a new push of 1 gives out_onehot=1<<1.
- Exhaustive decode, SEL_W=3: sweep in_sel 0..7 with in_enable=1 -> out_onehot=1<<in_sel, exactly one bit set each time.
